mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage initiator for the word-addressed data memory of the pipelined MIPS CPU.
//  Takes load/store requests from EX/MEM and drives the memory's Raddr/Waddr/Wdata/MemRead/MemWrite.
//  Implements LB/LBU/LH/LHU/LW and SB/SH/SW; partial stores use read-modify-write.
//  Stalls the pipeline until each access completes.
// PARAMETERS
//  W        128  memory depth in 32-bit words; valid byte addresses are 0 .. 4*W-1
// PORTS
//  clk        in   1   single clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  mem_req    in   1   request valid from EX/MEM; held stable while stall=1
//  mem_op     in   3   0 LB,1 LBU,2 LH,3 LHU,4 LW,5 SB,6 SH,7 SW
//  mem_addr   in   32  byte address
//  mem_wdata  in   32  store data; SB uses [7:0], SH uses [15:0]
//  stall      out  1   freeze IF..EX/MEM
//  done       out  1   one-cycle pulse: access complete
//  err        out  1   with done: misaligned/out-of-range, no access performed
//  rdata_out  out  32  load result, valid with done; holds until next done
//  Raddr      out  32  memory read byte address (word-aligned)
//  Waddr      out  32  memory write byte address (word-aligned)
//  Wdata      out  32  memory write word
//  MemRead    out  1   memory read enable
//  MemWrite   out  1   memory write enable
//  Rdata      in   32  memory read word (combinational)
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE. Async: mid-access rst drops MemRead/MemWrite immediately; in-flight store lost.
//  FSM: IDLE, READ, MERGE, WRITE, RESP. Requests sampled only in IDLE.
//  stall = (IDLE & mem_req) | READ | MERGE | WRITE (combinational); stall=0 in RESP.
//  Loads:  IDLE->READ->RESP. READ: MemRead=1, Raddr={addr[31:2],2'b00}; Rdata registered at end of READ.
//  SW:     IDLE->WRITE->RESP. WRITE: MemWrite=1 exactly one cycle, Wdata=mem_wdata.
//  SB/SH:  IDLE->READ->MERGE->WRITE->RESP. MERGE replaces addressed lane(s) of captured word.
//  Lanes little-endian: byte offset k = bits[8k+7:8k]; halfword offset 2 = bits[31:16].
//  LB/LH sign-extend; LBU/LHU zero-extend; LW passes word.
//  Out-of-range (addr >= 4*W): IDLE->RESP, err=1, rdata_out=0, no MemRead/MemWrite.
//  MemRead and MemWrite never both 1; both 0 in IDLE/MERGE/RESP.
//  RESP: done=1 for one cycle, -> IDLE; next request accepted the following cycle.
//  Latency from acceptance: load 2 cycles, SW 2, SB/SH 4 (done in RESP).
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: LW/SW with addr[1:0]!=0 or LH/LHU/SH with addr[0]!=0
//    -> IDLE->RESP, err=1, no memory access.
//  Undefined: misalignment not checked; low bits ignored for word ops, addr[0] ignored for
//    halfword ops; err raised only for out-of-range.
// STRUCTURE
//  Package mem_access_pkg: mem_op encodings, FSM state enum, lane/extend helper constants.
//  Sub-module byte_lane_align (combinational): load extract+extend, store merge.
// TESTING
//  Memory model preloaded word 10=0x55AA55AA (byte 0x28), word 11=0x77887788 (byte 0x2C).
//  LW 0x28 -> stall 2 cycles, done cycle 2, rdata_out=0x55AA55AA, MemRead 1 cycle.
//  LB 0x28 -> 0xFFFFFFAA; LBU 0x28 -> 0x000000AA; LH 0x2E -> 0x00007788.
//  SB 0x2E wdata 0x000000AB -> MemWrite 1 cycle, then LW 0x2C -> 0x77AB7788.
//  SW 0x2D 0x12345678: with MISALIGN_TRAP_EN err=1, word 11 unchanged; without, word 11=0x12345678.
//  SH 0x28 with rst pulsed in MERGE -> MemWrite never high, stall=0, word 10 unchanged.
//  LW 0x200 (W=128) -> done+err, rdata_out=0, MemRead never high.

Source files
------------

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared encodings and helpers for the MEM-stage access unit
package mem_access_pkg;

    typedef enum logic [2:0] {
        OP_LB  = 3'd0,
        OP_LBU = 3'd1,
        OP_LH  = 3'd2,
        OP_LHU = 3'd3,
        OP_LW  = 3'd4,
        OP_SB  = 3'd5,
        OP_SH  = 3'd6,
        OP_SW  = 3'd7
    } mem_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    function automatic logic is_store(input logic [2:0] op);
        return op >= OP_SB;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lsb);
        logic word_op;
        logic half_op;
        word_op = (op == OP_LW) || (op == OP_SW);
        half_op = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
        return (word_op && (lsb != 2'b00)) || (half_op && lsb[0]);
    endfunction

endpackage

// File: rtl/byte_lane_align.sv
// rtl/byte_lane_align.sv - little-endian lane extract/extend for loads and lane merge for stores
module byte_lane_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] load_word_i,
    input  logic [31:0] merge_word_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_o
);

    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halfword ops only look at offset bit 1, so an unaligned halfword folds onto its pair.
    assign byte_shift = {offset_i, 3'b000};
    assign half_shift = {offset_i[1], 4'b0000};
    assign byte_sel   = load_word_i[byte_shift +: BYTE_W];
    assign half_sel   = load_word_i[half_shift +: HALF_W];

    always_comb begin
        load_data_o = load_word_i;
        case (op_i)
            OP_LB:   load_data_o = {{(32 - BYTE_W){byte_sel[7]}}, byte_sel};
            OP_LBU:  load_data_o = {{(32 - BYTE_W){1'b0}}, byte_sel};
            OP_LH:   load_data_o = {{(32 - HALF_W){half_sel[15]}}, half_sel};
            OP_LHU:  load_data_o = {{(32 - HALF_W){1'b0}}, half_sel};
            default: load_data_o = load_word_i;
        endcase
    end

    always_comb begin
        merged_o = merge_word_i;
        case (op_i)
            OP_SB:   merged_o[byte_shift +: BYTE_W] = store_data_i[7:0];
            OP_SH:   merged_o[half_shift +: HALF_W] = store_data_i[15:0];
            OP_SW:   merged_o = store_data_i;
            default: merged_o = merge_word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store initiator with read-modify-write partial stores (MISALIGN_TRAP_EN: trap misaligned accesses)
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int W = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic [2:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata_out,
    output logic [31:0] Raddr,
    output logic [31:0] Waddr,
    output logic [31:0] Wdata,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] Rdata
);

    localparam logic [31:0] ADDR_LIMIT = 32'(4 * W);

    state_e      state_q;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic        done_q;
    logic        err_q;
    logic [31:0] rdata_out_q;
    logic [31:0] raddr_q;
    logic [31:0] waddr_q;
    logic [31:0] mem_wdata_q;
    logic        mem_read_q;
    logic        mem_write_q;

    logic [31:0] load_data;
    logic [31:0] merged_word;
    logic        req_bad;

    always_comb begin
        req_bad = (mem_addr >= ADDR_LIMIT);
`ifdef MISALIGN_TRAP_EN
        req_bad = req_bad | is_misaligned(mem_op, mem_addr[1:0]);
`endif
    end

    byte_lane_align u_align (
        .op_i         (op_q),
        .offset_i     (addr_q[1:0]),
        .load_word_i  (Rdata),
        .merge_word_i (word_q),
        .store_data_i (wdata_q),
        .load_data_o  (load_data),
        .merged_o     (merged_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= 3'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            word_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_out_q <= '0;
            raddr_q     <= '0;
            waddr_q     <= '0;
            mem_wdata_q <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_req) begin
                        op_q    <= mem_op;
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        if (req_bad) begin
                            state_q     <= ST_RESP;
                            done_q      <= 1'b1;
                            err_q       <= 1'b1;
                            rdata_out_q <= '0;
                        end else if (mem_op == OP_SW) begin
                            state_q     <= ST_WRITE;
                            waddr_q     <= {mem_addr[31:2], 2'b00};
                            mem_wdata_q <= mem_wdata;
                            mem_write_q <= 1'b1;
                        end else begin
                            state_q    <= ST_READ;
                            raddr_q    <= {mem_addr[31:2], 2'b00};
                            mem_read_q <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    mem_read_q <= 1'b0;
                    word_q     <= Rdata;
                    if (is_store(op_q)) begin
                        state_q <= ST_MERGE;
                    end else begin
                        state_q     <= ST_RESP;
                        done_q      <= 1'b1;
                        rdata_out_q <= load_data;
                    end
                end
                ST_MERGE: begin
                    state_q     <= ST_WRITE;
                    waddr_q     <= {addr_q[31:2], 2'b00};
                    mem_wdata_q <= merged_word;
                    mem_write_q <= 1'b1;
                end
                ST_WRITE: begin
                    state_q     <= ST_RESP;
                    mem_write_q <= 1'b0;
                    done_q      <= 1'b1;
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    done_q      <= 1'b0;
                    err_q       <= 1'b0;
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

    // The request is stalled in its acceptance cycle so EX/MEM holds it until RESP.
    assign stall = ((state_q == ST_IDLE) && mem_req) || (state_q == ST_READ) ||
                   (state_q == ST_MERGE) || (state_q == ST_WRITE);

    assign done      = done_q;
    assign err       = err_q;
    assign rdata_out = rdata_out_q;
    assign Raddr     = raddr_q;
    assign Waddr     = waddr_q;
    assign Wdata     = mem_wdata_q;
    assign MemRead   = mem_read_q;
    assign MemWrite  = mem_write_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit against a word-array reference model
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req;
    logic [2:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] rdata_out;
    logic [31:0] Raddr;
    logic [31:0] Waddr;
    logic [31:0] Wdata;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Rdata;

    logic [31:0] env_mem [0:127];
    logic [31:0] ref_mem [0:127];

    int checks = 0;
    int errors = 0;
    int both_cnt = 0;

    mem_access_unit #(.W(128)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_req   (mem_req),
        .mem_op    (mem_op),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .stall     (stall),
        .done      (done),
        .err       (err),
        .rdata_out (rdata_out),
        .Raddr     (Raddr),
        .Waddr     (Waddr),
        .Wdata     (Wdata),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Rdata     (Rdata)
    );

    always #5 clk = ~clk;

    assign Rdata = (Raddr < 32'd512) ? env_mem[Raddr[8:2]] : 32'hDEADBEEF;

    always @(posedge clk) begin
        if (MemWrite && (Waddr < 32'd512))
            env_mem[Waddr[8:2]] <= Wdata;
    end

    always @(negedge clk) begin
        if (MemRead && MemWrite)
            both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                         output logic e, output logic [31:0] rd);
        int idx;
        int bpos;
        int hpos;
        logic [31:0] w;
        logic [31:0] b;
        logic [31:0] h;
        e  = 1'b0;
        rd = '0;
        if (a >= 32'd512) begin
            e = 1'b1;
            return;
        end
`ifdef MISALIGN_TRAP_EN
        if (((op == 3'd4 || op == 3'd7) && (a % 4 != 0)) ||
            ((op == 3'd2 || op == 3'd3 || op == 3'd6) && (a % 2 != 0))) begin
            e = 1'b1;
            return;
        end
`endif
        idx  = int'(a / 4);
        bpos = 8 * int'(a % 4);
        hpos = 16 * int'((a % 4) / 2);
        w = ref_mem[idx];
        b = (w >> bpos) & 32'hFF;
        h = (w >> hpos) & 32'hFFFF;
        case (op)
            3'd0: rd = (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
            3'd1: rd = b;
            3'd2: rd = (h >= 32'h8000) ? (h | 32'hFFFF0000) : h;
            3'd3: rd = h;
            3'd4: rd = w;
            3'd5: ref_mem[idx] = (w & ~(32'hFF << bpos)) | ((wd & 32'hFF) << bpos);
            3'd6: ref_mem[idx] = (w & ~(32'hFFFF << hpos)) | ((wd & 32'hFFFF) << hpos);
            default: ref_mem[idx] = wd;
        endcase
    endtask

    task automatic access(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd);
        logic        exp_err;
        logic [31:0] exp_rd;
        logic        got_err;
        logic [31:0] got_rd;
        logic        got;
        int cyc, stalls, rds, wrs, addr_bad;
        int lat_exp, rd_exp, wr_exp;
        model(op, a, wd, exp_err, exp_rd);
        @(negedge clk);
        mem_req = 1'b1; mem_op = op; mem_addr = a; mem_wdata = wd;
        cyc = 0; stalls = 0; rds = 0; wrs = 0; addr_bad = 0;
        got = 1'b0; got_err = 1'b0; got_rd = '0;
        while (!got && cyc < 20) begin
            #1;
            if (stall) stalls++;
            if (MemRead) begin
                rds++;
                if (Raddr !== {a[31:2], 2'b00}) addr_bad++;
            end
            if (MemWrite) begin
                wrs++;
                if (Waddr !== {a[31:2], 2'b00}) addr_bad++;
            end
            if (done) begin
                got = 1'b1; got_err = err; got_rd = rdata_out;
                mem_req = 1'b0;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        mem_req = 1'b0;
        if (exp_err) begin
            lat_exp = 1; rd_exp = 0; wr_exp = 0;
        end else if (op == 3'd7) begin
            lat_exp = 2; rd_exp = 0; wr_exp = 1;
        end else if (op >= 3'd5) begin
            lat_exp = 4; rd_exp = 1; wr_exp = 1;
        end else begin
            lat_exp = 2; rd_exp = 1; wr_exp = 0;
        end
        check("done_seen", 32'(got), 32'd1);
        check("err", 32'(got_err), 32'(exp_err));
        check("latency", cyc, lat_exp);
        check("stall_cycles", stalls, lat_exp);
        check("memread_cycles", rds, rd_exp);
        check("memwrite_cycles", wrs, wr_exp);
        check("mem_addr_out", addr_bad, 0);
        if (exp_err || op < 3'd5)
            check("rdata_out", got_rd, exp_rd);
        @(negedge clk);
        #1;
        check("done_pulse", 32'(done), 32'd0);
        check("idle_stall", 32'(stall), 32'd0);
        if (!exp_err && op >= 3'd5)
            check("mem_word", env_mem[a[8:2]], ref_mem[a[8:2]]);
        rd = got_rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] v;
        logic [31:0] a;
        int wr;
        rst = 1'b0; mem_req = 1'b0; mem_op = '0; mem_addr = '0; mem_wdata = '0;
        for (int i = 0; i < 128; i++) begin
            v = $urandom;
            env_mem[i] = v;
            ref_mem[i] = v;
        end
        env_mem[10] = 32'h55AA55AA; ref_mem[10] = 32'h55AA55AA;
        env_mem[11] = 32'h77887788; ref_mem[11] = 32'h77887788;

        #2 rst = 1'b1;
        #2;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata_out", rdata_out, 32'd0);
        check("rst_raddr", Raddr, 32'd0);
        check("rst_waddr", Waddr, 32'd0);
        check("rst_wdata", Wdata, 32'd0);
        check("rst_memread", 32'(MemRead), 32'd0);
        check("rst_memwrite", 32'(MemWrite), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;

        access(3'd4, 32'h28, 32'h0, r);
        check("lw_0x28", r, 32'h55AA55AA);
        access(3'd0, 32'h28, 32'h0, r);
        check("lb_0x28", r, 32'hFFFFFFAA);
        access(3'd1, 32'h28, 32'h0, r);
        check("lbu_0x28", r, 32'h000000AA);
        access(3'd2, 32'h2E, 32'h0, r);
        check("lh_0x2e", r, 32'h00007788);
        access(3'd5, 32'h2E, 32'h000000AB, r);
        access(3'd4, 32'h2C, 32'h0, r);
        check("sb_then_lw_0x2c", r, 32'h77AB7788);
        access(3'd7, 32'h2D, 32'h12345678, r);
`ifdef MISALIGN_TRAP_EN
        check("sw_misaligned_word11", env_mem[11], 32'h77AB7788);
`else
        check("sw_misaligned_word11", env_mem[11], 32'h12345678);
`endif

        // Reset while the SH sits in MERGE: the store must be abandoned.
        @(negedge clk);
        mem_req = 1'b1; mem_op = 3'd6; mem_addr = 32'h28; mem_wdata = 32'h0000BEEF;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("merge_stall", 32'(stall), 32'd1);
        check("merge_memwrite", 32'(MemWrite), 32'd0);
        mem_req = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_memwrite", 32'(MemWrite), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        wr = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (MemWrite) wr++;
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #1;
            if (MemWrite) wr++;
        end
        check("midrst_no_write", wr, 0);
        check("midrst_word10", env_mem[10], 32'h55AA55AA);

        access(3'd4, 32'h200, 32'h0, r);
        check("oor_lw_rdata", r, 32'h0);

        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) == 0)
                a = 32'd512 + 32'($urandom_range(0, 300));
            else
                a = 32'($urandom_range(0, 511));
            access(3'($urandom_range(0, 7)), a, $urandom, r);
        end

        for (int i = 0; i < 128; i++)
            check("final_mem", env_mem[i], ref_mem[i]);
        check("memread_memwrite_overlap", both_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
